// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared state encoding and packed payload layout for stage registers
package mips_pipe_pkg;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    // Payload packing, MSB first: {wb_en, mem_r_en, alu, mem, dest}
    function automatic int pl_w(input int dw, input int rw);
        return 2 + 2 * dw + rw;
    endfunction

    function automatic int mem_lsb(input int rw);
        return rw;
    endfunction

    function automatic int alu_lsb(input int dw, input int rw);
        return rw + dw;
    endfunction

    function automatic int mr_bit(input int dw, input int rw);
        return rw + 2 * dw;
    endfunction

    function automatic int wb_bit(input int dw, input int rw);
        return rw + 2 * dw + 1;
    endfunction

endpackage

// File: rtl/mips_stage_skid_reg.sv
// mips_stage_skid_reg: MEM/WB-style stage register with valid/ready, one-entry skid, flush, forwarding tap and stall counter
module mips_stage_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_mem,
    output logic [DEST_W-1:0] out_dest,
    output logic              fwd_en,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW    = pl_w(DATA_W, DEST_W);
    localparam int MEM_L = mem_lsb(DEST_W);
    localparam int ALU_L = alu_lsb(DATA_W, DEST_W);
    localparam int MR_B  = mr_bit(DATA_W, DEST_W);
    localparam int WB_B  = wb_bit(DATA_W, DEST_W);

    state_t        state, state_n;
    logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;

    assign in_pl = {in_wb_en, in_mem_r_en, in_alu, in_mem, in_dest};

    always_comb begin
        state_n = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush)
            state_n = EMPTY;
        else
            case (state)
                EMPTY: if (in_valid) begin
                    state_n = FULL;
                    main_d  = in_pl;
                end
                FULL: if (out_ready) begin
                    state_n = in_valid ? FULL : EMPTY;
                    main_d  = in_valid ? in_pl : main_q;
                end else if (in_valid) begin
                    state_n = SKID;
                    skid_d  = in_pl;
                end
                SKID: if (out_ready) begin
                    state_n = FULL;
                    main_d  = skid_q;
                end
                default: state_n = EMPTY;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_d;
            skid_q <= skid_d;
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready     = state != SKID;
    assign out_valid    = state != EMPTY;
    assign out_wb_en    = main_q[WB_B] & out_valid;
    assign out_mem_r_en = main_q[MR_B] & out_valid;
    assign out_alu      = main_q[ALU_L +: DATA_W];
    assign out_mem      = main_q[MEM_L +: DATA_W];
    assign out_dest     = main_q[DEST_W-1:0];
    // Only the main entry is architecturally "next to retire", so only it forwards
    assign fwd_en       = out_wb_en && out_dest != '0;
    assign fwd_dest     = out_dest;
    assign fwd_value    = out_mem_r_en ? out_mem : out_alu;

endmodule

// File: tb/tb_mips_stage_skid_reg.sv
// tb_mips_stage_skid_reg: directed plus randomized checks against a queue-based reference model
module tb_mips_stage_skid_reg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;

    logic          clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic          in_wb_en = 0, in_mem_r_en = 0;
    logic [DW-1:0] in_alu = 0, in_mem = 0;
    logic [RW-1:0] in_dest = 0;
    logic          in_ready, out_valid, out_wb_en, out_mem_r_en, fwd_en;
    logic [DW-1:0] out_alu, out_mem, fwd_value;
    logic [RW-1:0] out_dest, fwd_dest;
    logic [CW-1:0] stall_cnt;

    mips_stage_skid_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
        .in_alu(in_alu), .in_mem(in_mem), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
        .out_alu(out_alu), .out_mem(out_mem), .out_dest(out_dest),
        .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wb;
        logic          mr;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [RW-1:0] dest;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    endtask

    // Stage holds at most two entries, delivered in arrival order; flush empties it
    task automatic model_edge();
        bit in_x, out_x;
        ent_t e;
        if (q.size() > 0 && !out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
        in_x  = in_valid && q.size() < 2;
        out_x = q.size() > 0 && out_ready;
        e = '{in_wb_en, in_mem_r_en, in_alu, in_mem, in_dest};
        if (flush) q.delete();
        else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(e);
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (q.size() == 0) begin
            chk("idle_wb_en", out_wb_en, 0);
            chk("idle_mem_r_en", out_mem_r_en, 0);
            chk("idle_fwd_en", fwd_en, 0);
        end else begin
            chk("out_wb_en", out_wb_en, q[0].wb);
            chk("out_mem_r_en", out_mem_r_en, q[0].mr);
            chk("out_alu", out_alu, q[0].alu);
            chk("out_mem", out_mem, q[0].mem);
            chk("out_dest", out_dest, q[0].dest);
            chk("fwd_en", fwd_en, q[0].wb && q[0].dest != 0);
            chk("fwd_dest", fwd_dest, q[0].dest);
            chk("fwd_value", fwd_value, q[0].mr ? q[0].mem : q[0].alu);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr,
                         input logic [DW-1:0] a, input logic [DW-1:0] m, input logic [RW-1:0] d);
        in_valid = v; in_wb_en = wb; in_mem_r_en = mr; in_alu = a; in_mem = m; in_dest = d;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        compare();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_alu", out_alu, 0);

        out_ready = 1;
        drive(1, 1, 0, 32'h11, 0, 3); step();
        chk("stream0", out_alu, 32'h11);
        drive(1, 1, 0, 32'h22, 0, 3); step();
        chk("stream1", out_alu, 32'h22);
        chk("stream_ready", in_ready, 1);
        drive(1, 1, 0, 32'h33, 0, 3); step();
        chk("stream2", out_alu, 32'h33);
        drive(0, 0, 0, 0, 0, 0); step();
        chk("stream_done", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        drive(1, 1, 0, 32'hA, 0, 4); step();
        drive(1, 1, 0, 32'hB, 0, 4); out_ready = 0; step();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_main", out_alu, 32'hA);
        chk("skid_stall1", stall_cnt, 1);
        drive(0, 0, 0, 0, 0, 0); step();
        chk("skid_stall2", stall_cnt, 2);
        out_ready = 1; step();
        chk("drain_a_then_b", out_alu, 32'hB);
        step();
        chk("drain_empty", out_valid, 0);
        chk("drain_stall", stall_cnt, 2);

        drive(1, 1, 0, 32'hC, 0, 6); step();
        drive(1, 1, 0, 32'hD, 0, 6); out_ready = 0; step();
        drive(1, 1, 0, 32'hE, 0, 6); flush = 1; step();
        flush = 0; drive(0, 0, 0, 0, 0, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_wb_en", out_wb_en, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_keeps_cnt", stall_cnt, 3);
        out_ready = 1; step(); step();
        chk("flush_dropped", out_valid, 0);

        drive(1, 1, 1, 32'h5, 32'hDEAD, 7); step();
        chk("fwd_load_en", fwd_en, 1);
        chk("fwd_load_val", fwd_value, 32'hDEAD);
        drive(1, 1, 1, 32'h5, 32'hDEAD, 0); step();
        chk("fwd_r0", fwd_en, 0);
        drive(1, 1, 0, 32'h5, 32'hDEAD, 7); step();
        chk("fwd_alu_val", fwd_value, 32'h5);
        drive(0, 0, 0, 0, 0, 0); step();

        drive(1, 1, 1, 32'h77, 32'h88, 9); step();
        drive(1, 1, 1, 32'h99, 32'hAA, 9); out_ready = 0; step();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1;
        q.delete(); m_cnt = 0;
        chk("arst_valid", out_valid, 0);
        chk("arst_alu", out_alu, 0);
        chk("arst_wb_en", out_wb_en, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 0;
        compare();

        drive(1, 0, 0, 32'h1, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk("cnt_saturate", stall_cnt, 3);
        out_ready = 1; step();

        rst = 1; @(negedge clk); rst = 0; q.delete(); m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 70, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
            out_ready = $urandom_range(99) < 60;
            flush = $urandom_range(99) < 5;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
